dma_arbiter: RTL and testbench

Shares the single DMA read engine of the fully-connected layer between several fetch requesters (weight fetch, input-vector fetch, bias fetch). Requesters post an address/count pair; the arbiter grants one at a time in round-robin order, drives the DMA read handshake, and reports completion or timeout per requester. It sits between the layer sequencer's fetch units and the DMA.

---
 rtl/fc_pkg.sv | 14 +
 rtl/dma_arbiter_if.sv | 27 ++
 rtl/dma_arbiter_rr_picker.sv | 34 +++
 rtl/dma_arbiter.sv | 153 +++++++++++++++
 tb/tb_dma_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected layer fetch path.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int REQ_WEIGHT = 0;
  localparam int REQ_INPUT  = 1;
  localparam int REQ_BIAS   = 2;

endpackage

// File: rtl/dma_arbiter_if.sv
// Request/grant bundle between the fetch units, the arbiter and the DMA read engine.
interface dma_arbiter_if #(
  parameter int NUM_REQ           = 2,
  parameter int MEM_ADDRESS_WIDTH = 3
);
  logic [NUM_REQ-1:0]                        i_req;
  logic [NUM_REQ-1:0][MEM_ADDRESS_WIDTH-1:0] i_req_address;
  logic [NUM_REQ-1:0][MEM_ADDRESS_WIDTH-1:0] i_req_count;
  logic [NUM_REQ-1:0]                        o_grant;
  logic [NUM_REQ-1:0]                        o_done;
  logic [NUM_REQ-1:0]                        o_error;
  logic                                      o_dma_read;
  logic [MEM_ADDRESS_WIDTH-1:0]              o_dma_address;
  logic [MEM_ADDRESS_WIDTH-1:0]              o_dma_count;
  logic                                      i_dma_ready;
  logic                                      o_busy;

  modport master (
    output i_req, i_req_address, i_req_count, i_dma_ready,
    input  o_grant, o_done, o_error, o_dma_read, o_dma_address, o_dma_count, o_busy
  );

  modport slave (
    input  i_req, i_req_address, i_req_count, i_dma_ready,
    output o_grant, o_done, o_error, o_dma_read, o_dma_address, o_dma_count, o_busy
  );
endinterface

// File: rtl/dma_arbiter_rr_picker.sv
// Combinational round-robin select: first set request at or after ptr_i, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);
  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;
  logic             take_s;

  // scan candidates in priority order starting from the pointer
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    take_s  = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum_s   = {1'b0, ptr_i} + (IDX_W+1)'(off);
      cand_s  = (sum_s >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum_s - (IDX_W+1)'(NUM_REQ))
                                               : sum_s[IDX_W-1:0];
      take_s  = !valid_o && req_i[cand_s];
      idx_o   = take_s ? cand_s : idx_o;
      grant_o = take_s ? (NUM_REQ'(1) << cand_s) : grant_o;
      valid_o = valid_o | take_s;
    end
  end
endmodule

// File: rtl/dma_arbiter.sv
// Round-robin owner of the FC layer's single DMA read engine, with per-requester
// completion and timeout pulses.
module dma_arbiter #(
  parameter int NUM_REQ           = 2,
  parameter int WORD_SIZE         = 16,
  parameter int MEM_ADDRESS_WIDTH = 3,
  parameter int TIMEOUT           = 255
) (
  input logic          clk,
  input logic          i_rst_n,
  dma_arbiter_if.slave bus
);
  import fc_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int AW    = MEM_ADDRESS_WIDTH;

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_BUSY    = BUSY;
  localparam logic [1:0] ST_RELEASE = RELEASE;

  // Data words never pass through the arbiter; the width only tags which DMA it fronts.
  if (WORD_SIZE < 1 || NUM_REQ < 2 || TIMEOUT < 1) begin : g_bad_params
  end

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] error_q, error_d;
  logic               read_q, read_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW-1:0]      count_q, count_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] pick_grant_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_valid_s;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req_i   (bus.i_req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant_s),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  // next-state and output decode for the IDLE/BUSY/RELEASE handshake
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    done_d  = '0;
    error_d = '0;
    read_d  = read_q;
    addr_d  = addr_q;
    count_d = count_q;
    tmo_d   = tmo_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          grant_d = pick_grant_s;
          ptr_d   = (pick_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx_s + IDX_W'(1);
          addr_d  = bus.i_req_address[pick_idx_s];
          count_d = bus.i_req_count[pick_idx_s];
          zero_d  = (bus.i_req_count[pick_idx_s] == '0);
          read_d  = (bus.i_req_count[pick_idx_s] != '0);
          tmo_d   = '0;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // a zero-count grant completes without ever touching the DMA or waiting on ready
        if (zero_q) begin
          done_d  = grant_q;
          grant_d = '0;
          zero_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (bus.i_dma_ready) begin
          done_d  = grant_q;
          grant_d = '0;
          read_d  = 1'b0;
          state_d = ST_RELEASE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          error_d = grant_q;
          grant_d = '0;
          read_d  = 1'b0;
          state_d = ST_RELEASE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RELEASE: begin
        read_d = 1'b0;
        if (!bus.i_dma_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        read_d  = 1'b0;
        zero_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      error_q <= '0;
      read_q  <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      tmo_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      error_q <= error_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_grant       = grant_q;
  assign bus.o_done        = done_q;
  assign bus.o_error       = error_q;
  assign bus.o_dma_read    = read_q;
  assign bus.o_dma_address = addr_q;
  assign bus.o_dma_count   = count_q;
  assign bus.o_busy        = busy_q;
endmodule

// File: tb/tb_dma_arbiter.sv
// Scoreboard bench for dma_arbiter: expected grants/completions queued at stimulus time.
module tb_dma_arbiter;
  import fc_pkg::*;

  localparam int NR  = 2;
  localparam int AW  = 3;
  localparam int WS  = 16;
  localparam int TMO = 8;

  typedef struct {
    int            owner;
    logic [AW-1:0] addr;
    logic [AW-1:0] cnt;
    bit            err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_arbiter_if #(.NUM_REQ(NR), .MEM_ADDRESS_WIDTH(AW)) bus_if ();

  dma_arbiter #(
    .NUM_REQ(NR), .WORD_SIZE(WS), .MEM_ADDRESS_WIDTH(AW), .TIMEOUT(TMO)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if.slave)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  int   grant_log[$];

  int      dma_lat     = 5;
  bit      dma_auto    = 1'b1;
  bit      dma_hold    = 1'b0;
  int      read_cycles = 0;
  logic [WS-1:0] mem  [8];
  logic [WS-1:0] dbuf [8];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  // DMA model: raises ready dma_lat cycles into a read and fills dbuf from mem
  initial begin
    int dcnt = 0;
    bus_if.i_dma_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus_if.i_dma_ready = 1'b0;
        dcnt = 0;
      end else if (bus_if.o_dma_read) begin
        read_cycles++;
        if (dma_auto && dcnt == dma_lat - 1) begin
          for (int k = 0; k < 8; k++)
            if (k < int'(bus_if.o_dma_count)) dbuf[k] = mem[3'(int'(bus_if.o_dma_address) + k)];
          bus_if.i_dma_ready = 1'b1;
        end
        dcnt++;
      end else begin
        dcnt = 0;
        if (!dma_hold) bus_if.i_dma_ready = 1'b0;
      end
    end
  end

  // monitor: compare grants and done/error pulses against the scoreboard
  initial begin
    logic [NR-1:0] grant_prev = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        grant_prev = '0;
      end else begin
        if (bus_if.o_grant != '0 && grant_prev == '0) begin
          grant_log.push_back(onehot_idx(bus_if.o_grant));
          if (sb_q.size() == 0) begin
            check_value("unexpected_grant", 32'(bus_if.o_grant), 32'd0);
          end else begin
            check_value("grant", 32'(bus_if.o_grant), 32'(1 << sb_q[0].owner));
            check_value("dma_address", 32'(bus_if.o_dma_address), 32'(sb_q[0].addr));
            check_value("dma_count", 32'(bus_if.o_dma_count), 32'(sb_q[0].cnt));
          end
        end
        if ((bus_if.o_done | bus_if.o_error) != '0) begin
          check_value("done_error_excl", 32'(bus_if.o_done & bus_if.o_error), 32'd0);
          if (sb_q.size() == 0) begin
            check_value("unexpected_pulse", 32'(bus_if.o_done | bus_if.o_error), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check_value("pulse_owner", 32'(bus_if.o_done | bus_if.o_error), 32'(1 << e.owner));
            check_value("pulse_kind", 32'(bus_if.o_error != '0), 32'(e.err));
          end
        end
        grant_prev = bus_if.o_grant;
      end
    end
  end

  task automatic push_exp(input int owner, input logic [AW-1:0] addr, input logic [AW-1:0] cnt,
                          input bit err);
    exp_t e;
    e.owner = owner;
    e.addr  = addr;
    e.cnt   = cnt;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus_if.o_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_value(tag, 32'(bus_if.o_busy), 32'd0);
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (bus_if.o_grant == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_value(tag, 32'(bus_if.o_grant != '0), 32'd1);
  endtask

  initial begin
    int n;
    bus_if.i_req         = '0;
    bus_if.i_req_address = '0;
    bus_if.i_req_count   = '0;
    for (int i = 0; i < 8; i++) begin
      mem[i]  = WS'(16'hA000 + i * 16'h0111);
      dbuf[i] = '0;
    end

    repeat (3) @(negedge clk);
    check_value("rst_grant", 32'(bus_if.o_grant), 32'd0);
    check_value("rst_done", 32'(bus_if.o_done), 32'd0);
    check_value("rst_error", 32'(bus_if.o_error), 32'd0);
    check_value("rst_read", 32'(bus_if.o_dma_read), 32'd0);
    check_value("rst_addr", 32'(bus_if.o_dma_address), 32'd0);
    check_value("rst_count", 32'(bus_if.o_dma_count), 32'd0);
    check_value("rst_busy", 32'(bus_if.o_busy), 32'd0);
    rst_n = 1'b1;

    // single request, ready five cycles into the read; request dropped mid-transfer
    @(negedge clk);
    bus_if.i_req_address[REQ_WEIGHT] = 3'd1;
    bus_if.i_req_count[REQ_WEIGHT]   = 3'd4;
    dma_lat = 5;
    read_cycles = 0;
    push_exp(REQ_WEIGHT, 3'd1, 3'd4, 1'b0);
    bus_if.i_req = 2'b01;
    @(negedge clk);
    check_value("t1_read", 32'(bus_if.o_dma_read), 32'd1);
    check_value("t1_busy", 32'(bus_if.o_busy), 32'd1);
    bus_if.i_req = 2'b00;
    wait_idle("t1_idle");
    check_value("t1_read_cycles", 32'(read_cycles), 32'd5);
    for (int k = 0; k < 4; k++) check_value("t1_buffer", 32'(dbuf[k]), 32'(mem[k + 1]));

    // contention from reset: grants must alternate 0,1,0,1
    rst_n = 1'b0;
    bus_if.i_req_address[REQ_WEIGHT] = 3'd2;
    bus_if.i_req_count[REQ_WEIGHT]   = 3'd2;
    bus_if.i_req_address[REQ_INPUT]  = 3'd6;
    bus_if.i_req_count[REQ_INPUT]    = 3'd3;
    bus_if.i_req = 2'b11;
    dma_lat = 3;
    grant_log.delete();
    for (int i = 0; i < 4; i++)
      push_exp(i % 2, (i % 2 == 0) ? 3'd2 : 3'd6, (i % 2 == 0) ? 3'd2 : 3'd3, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (grant_log.size() < 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    bus_if.i_req = 2'b00;
    check_value("t2_grants_seen", 32'(grant_log.size()), 32'd4);
    wait_idle("t2_idle");
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_value("t2_order", 32'(grant_log[i]), 32'(i % 2));

    // zero count: one-cycle grant, no read, done on the following cycle
    bus_if.i_req_address[REQ_INPUT] = 3'd5;
    bus_if.i_req_count[REQ_INPUT]   = 3'd0;
    read_cycles = 0;
    push_exp(REQ_INPUT, 3'd5, 3'd0, 1'b0);
    bus_if.i_req = 2'b10;
    @(negedge clk);
    check_value("t3_grant", 32'(bus_if.o_grant), 32'd2);
    check_value("t3_read", 32'(bus_if.o_dma_read), 32'd0);
    check_value("t3_no_done_yet", 32'(bus_if.o_done), 32'd0);
    bus_if.i_req = 2'b00;
    @(negedge clk);
    check_value("t3_grant_clr", 32'(bus_if.o_grant), 32'd0);
    check_value("t3_done", 32'(bus_if.o_done), 32'd2);
    check_value("t3_idle", 32'(bus_if.o_busy), 32'd0);
    check_value("t3_read_cycles", 32'(read_cycles), 32'd0);

    // timeout: ready never comes
    dma_auto = 1'b0;
    bus_if.i_req_address[REQ_WEIGHT] = 3'd2;
    bus_if.i_req_count[REQ_WEIGHT]   = 3'd3;
    read_cycles = 0;
    push_exp(REQ_WEIGHT, 3'd2, 3'd3, 1'b1);
    bus_if.i_req = 2'b01;
    @(negedge clk);
    bus_if.i_req = 2'b00;
    wait_idle("t4_idle");
    check_value("t4_read_cycles", 32'(read_cycles), 32'(TMO));

    // ready held high after done keeps the arbiter in RELEASE
    dma_auto = 1'b1;
    dma_hold = 1'b1;
    dma_lat  = 2;
    bus_if.i_req_address[REQ_INPUT] = 3'd7;
    bus_if.i_req_count[REQ_INPUT]   = 3'd1;
    push_exp(REQ_INPUT, 3'd7, 3'd1, 1'b0);
    bus_if.i_req = 2'b10;
    @(negedge clk);
    bus_if.i_req = 2'b01;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check_value("t5_held_busy", 32'(bus_if.o_busy), 32'd1);
    check_value("t5_no_grant", 32'(bus_if.o_grant), 32'd0);
    push_exp(REQ_WEIGHT, 3'd2, 3'd3, 1'b0);
    dma_hold = 1'b0;
    wait_grant("t5_grant_after_drop");
    bus_if.i_req = 2'b00;
    wait_idle("t5_idle");

    // reset mid-transfer with the pointer sitting at requester 1
    dma_auto = 1'b0;
    bus_if.i_req_address[REQ_WEIGHT] = 3'd4;
    bus_if.i_req_count[REQ_WEIGHT]   = 3'd2;
    push_exp(REQ_WEIGHT, 3'd4, 3'd2, 1'b0);
    bus_if.i_req = 2'b01;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check_value("t6_read_before", 32'(bus_if.o_dma_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("t6_rst_read", 32'(bus_if.o_dma_read), 32'd0);
    check_value("t6_rst_grant", 32'(bus_if.o_grant), 32'd0);
    check_value("t6_rst_busy", 32'(bus_if.o_busy), 32'd0);
    sb_q.delete();
    dma_auto = 1'b1;
    dma_lat  = 2;
    bus_if.i_req = 2'b11;
    push_exp(REQ_WEIGHT, 3'd4, 3'd2, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant("t6_grant_seen");
    check_value("t6_first_grant", 32'(bus_if.o_grant), 32'd1);
    bus_if.i_req = 2'b00;
    wait_idle("t6_idle");

    check_value("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
